// File: rtl/jump_idfr_ras.sv
// Jump identifier with return-address stack.
// Decodes JAL/JALR, computes the link address, and keeps a circular RAS
// that predicts return targets. The result sits in a single output register
// with a valid/ready handshake.
module jump_idfr_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned RAS_DEPTH = 8,
  parameter logic [ID_W-1:0] NONE_ID = 0,
  parameter logic [ID_W-1:0] JAL_ID  = 1,
  parameter logic [ID_W-1:0] JALR_ID = 2,
  localparam int unsigned PW = $clog2(RAS_DEPTH),
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] instr_id,
  output logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_hit,
  output logic [CW-1:0]   ras_count
);

  // Stack storage; wr_ptr points at the slot the next push writes, so the
  // top entry lives at wr_ptr-1 (wrapping, which makes overflow circular).
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   top_idx;

  logic            accept;
  logic            is_jal;
  logic            is_jalr;
  logic            rd_link;
  logic            rs1_link;
  logic            do_push;
  logic            do_pop;
  logic            empty;
  logic [XLEN-1:0] link_val;
  logic [ID_W-1:0] id_val;
  logic [XLEN-1:0] target_val;
  logic            hit_val;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign link_val = pc + XLEN'(4);
  assign top_idx  = wr_ptr - PW'(1);
  assign empty    = (ras_count == '0);

  // Decode the instruction and choose the stack action.
  always_comb begin
    id_val  = NONE_ID;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (is_jal) begin
      id_val  = JAL_ID;
      do_push = rd_link;
    end else if (is_jalr) begin
      id_val = JALR_ID;
      if (rd_link && !rs1_link) begin
        do_push = 1'b1;
      end else if (!rd_link && rs1_link) begin
        do_pop = 1'b1;
      end else if (rd_link && rs1_link) begin
        do_push = 1'b1;
        do_pop  = (rd != rs1);
      end
    end
  end

  // Predicted return target: only a pop of a non-empty stack produces a hit.
  always_comb begin
    target_val = '0;
    hit_val    = 1'b0;
    if (do_pop && !empty) begin
      target_val = ras_mem[top_idx];
      hit_val    = 1'b1;
    end
  end

  // Stack state; only changes on an accepted instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      ras_count <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem[i] <= '0;
      end
    end else if (accept) begin
      if (do_pop && do_push) begin
        if (empty) begin
          // Nothing to pop, so this degenerates to a plain push.
          ras_mem[wr_ptr] <= link_val;
          wr_ptr          <= wr_ptr + PW'(1);
          ras_count       <= CW'(1);
        end else begin
          ras_mem[top_idx] <= link_val;
        end
      end else if (do_push) begin
        ras_mem[wr_ptr] <= link_val;
        wr_ptr          <= wr_ptr + PW'(1);
        if (ras_count != CW'(RAS_DEPTH)) begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (do_pop && !empty) begin
        wr_ptr    <= top_idx;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // Output register: load on accept, drop on flush or on consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      instr_id    <= NONE_ID;
      link_addr   <= '0;
      pred_target <= '0;
      pred_hit    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      instr_id    <= id_val;
      link_addr   <= link_val;
      pred_target <= target_val;
      pred_hit    <= hit_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jump_idfr_ras.sv
// Directed bench for jump_idfr_ras with hand-computed expectations.
module tb_jump_idfr_ras;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ID_W = 8;
  localparam int unsigned CW   = 4;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] instr_id;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] pred_target;
  logic            pred_hit;
  logic [CW-1:0]   ras_count;

  int n_checks = 0;
  int n_fail   = 0;

  jump_idfr_ras dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .rd          (rd),
    .rs1         (rs1),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr_id    (instr_id),
    .link_addr   (link_addr),
    .pred_target (pred_target),
    .pred_hit    (pred_hit),
    .ras_count   (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle and sample just after the edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdn,
                      input logic [4:0] rs1n, input logic [31:0] pcv);
    opcode   = op;
    funct3   = f3;
    rd       = rdn;
    rs1      = rs1n;
    pc       = pcv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] id, input logic [31:0] link,
                           input logic [31:0] tgt, input logic hit, input logic [3:0] cnt);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, ".id"}, 64'(instr_id), 64'(id));
    check_eq({tag, ".link"}, 64'(link_addr), 64'(link));
    check_eq({tag, ".target"}, 64'(pred_target), 64'(tgt));
    check_eq({tag, ".hit"}, 64'(pred_hit), 64'(hit));
    check_eq({tag, ".count"}, 64'(ras_count), 64'(cnt));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    funct3    = '0;
    rd        = '0;
    rs1       = '0;
    pc        = '0;
    #1;
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.id", 64'(instr_id), 64'd0);
    check_eq("rst.link", 64'(link_addr), 64'd0);
    check_eq("rst.target", 64'(pred_target), 64'd0);
    check_eq("rst.hit", 64'(pred_hit), 64'd0);
    check_eq("rst.count", 64'(ras_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("idle.in_ready", 64'(in_ready), 64'd1);

    // Call then return.
    send(OP_JAL, 3'd0, 5'd1, 5'd0, 32'h100);
    check_out("jal_call", 8'd1, 32'h104, 32'h0, 1'b0, 4'd1);
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h104);
    check_out("jalr_ret", 8'd2, 32'h108, 32'h104, 1'b1, 4'd0);
    @(posedge clk);
    #1;
    check_eq("drain.valid", 64'(out_valid), 64'd0);

    // Overflow: nine pushes into eight entries, the oldest is overwritten.
    for (int i = 0; i < 9; i++) begin
      send(OP_JAL, 3'd0, 5'd1, 5'd0, 32'(i * 16));
    end
    check_eq("ovf.count", 64'(ras_count), 64'd8);
    for (int k = 0; k < 8; k++) begin
      send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h1000);
      check_eq($sformatf("pop%0d.target", k), 64'(pred_target), 64'(32'h84 - 32'(16 * k)));
      check_eq($sformatf("pop%0d.hit", k), 64'(pred_hit), 64'd1);
      check_eq($sformatf("pop%0d.count", k), 64'(ras_count), 64'(7 - k));
    end
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h1000);
    check_out("pop_empty", 8'd2, 32'h1004, 32'h0, 1'b0, 4'd0);

    // Pop-then-push on a stack holding 0x200.
    send(OP_JAL, 3'd0, 5'd1, 5'd0, 32'h1fc);
    check_eq("push200.count", 64'(ras_count), 64'd1);
    send(OP_JALR, 3'd0, 5'd5, 5'd1, 32'h300);
    check_out("poppush", 8'd2, 32'h304, 32'h200, 1'b1, 4'd1);
    send(OP_JALR, 3'd1, 5'd1, 5'd1, 32'h320);
    check_out("jalr_f3_1", 8'd0, 32'h324, 32'h0, 1'b0, 4'd1);
    send(OP_JALR, 3'd0, 5'd0, 5'd5, 32'h340);
    check_out("pop304", 8'd2, 32'h344, 32'h304, 1'b1, 4'd0);

    // Pop-then-push on an empty stack acts as a push.
    send(OP_JALR, 3'd0, 5'd1, 5'd5, 32'h400);
    check_out("poppush_empty", 8'd2, 32'h404, 32'h0, 1'b0, 4'd1);
    // rd == rs1 == link is a push.
    send(OP_JALR, 3'd0, 5'd5, 5'd5, 32'h410);
    check_out("jalr_same", 8'd2, 32'h414, 32'h0, 1'b0, 4'd2);
    // JAL to x0 takes no RAS action; non-jump wraps link.
    send(OP_JAL, 3'd0, 5'd0, 5'd0, 32'h420);
    check_out("jal_x0", 8'd1, 32'h424, 32'h0, 1'b0, 4'd2);
    send(7'b0110011, 3'd0, 5'd1, 5'd1, 32'hffff_fffc);
    check_out("none_wrap", 8'd0, 32'h0, 32'h0, 1'b0, 4'd2);
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h430);
    check_out("pop414", 8'd2, 32'h434, 32'h414, 1'b1, 4'd1);
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h440);
    check_out("pop404", 8'd2, 32'h444, 32'h404, 1'b1, 4'd0);

    // Backpressure: a held output blocks the next instruction.
    send(OP_JAL, 3'd0, 5'd1, 5'd0, 32'h500);
    check_out("pre_stall", 8'd1, 32'h504, 32'h0, 1'b0, 4'd1);
    out_ready = 1'b0;
    opcode    = OP_JAL;
    funct3    = 3'd0;
    rd        = 5'd1;
    rs1       = 5'd0;
    pc        = 32'h600;
    in_valid  = 1'b1;
    #1;
    check_eq("stall.in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("stall%0d", c), 8'd1, 32'h504, 32'h0, 1'b0, 4'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("unstall.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("unstall", 8'd1, 32'h604, 32'h0, 1'b0, 4'd2);

    // Flush drops the held output but leaves the stack alone.
    out_ready = 1'b0;
    flush     = 1'b1;
    pc        = 32'h650;
    in_valid  = 1'b1;
    #1;
    check_eq("flush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("flush.valid", 64'(out_valid), 64'd0);
    check_eq("flush.count", 64'(ras_count), 64'd2);
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h660);
    check_out("flush_pop", 8'd2, 32'h664, 32'h604, 1'b1, 4'd1);

    // Reset in the middle of a stall clears everything at once.
    out_ready = 1'b0;
    opcode    = OP_JAL;
    rd        = 5'd1;
    pc        = 32'h700;
    in_valid  = 1'b1;
    @(posedge clk);
    #2;
    check_eq("prerst.valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst.valid", 64'(out_valid), 64'd0);
    check_eq("midrst.id", 64'(instr_id), 64'd0);
    check_eq("midrst.link", 64'(link_addr), 64'd0);
    check_eq("midrst.target", 64'(pred_target), 64'd0);
    check_eq("midrst.hit", 64'(pred_hit), 64'd0);
    check_eq("midrst.count", 64'(ras_count), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check_eq("rstflush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("rstflush.valid", 64'(out_valid), 64'd0);
    check_eq("rstflush.count", 64'(ras_count), 64'd0);
    send(OP_JALR, 3'd0, 5'd0, 5'd1, 32'h800);
    check_out("post_rst_pop", 8'd2, 32'h804, 32'h0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
